// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle RV32I control unit.
// Sequences FETCH/DECODE/execute states for loads, stores, R/I ALU ops,
// BEQ/BNE, JAL, JALR and (optionally) LUI/AUIPC. It drives every datapath
// enable and mux select, waits on memory, traps on illegal instructions or
// a stalled memory, and pulses instr_retired once per completed instruction.
//
// Memory handshake: in FETCH, MEM_RD and MEM_WR the access is presented
// (address select, mem_write) and held unchanged every cycle until the cycle
// in which mem_ready is high; that cycle completes the access and the FSM
// advances on the following edge. With MEM_WAIT_EN=0 every cycle counts as
// ready. ir_write/pc_write in FETCH fire only in that completing cycle.
//
// State, sticky flags, the watchdog counter and instr_retired are registered.
// Control outputs are decoded from the registered state. A few of them also
// depend on the same-cycle mem_ready (FETCH) or zero (BRANCH) inputs.
module mc_control_fsm #(
  parameter bit          SUPPORT_UPPER  = 1'b1,
  parameter bit          MEM_WAIT_EN    = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_write,
  output logic       reg_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       adr_src,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_control,
  output logic [2:0] imm_src,
  output logic [3:0] current_state,
  output logic       illegal_instr,
  output logic       mem_timeout,
  output logic       instr_retired
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EXEC_R  = 4'd6,
    S_ALU_WB  = 4'd7,
    S_EXEC_I  = 4'd8,
    S_JAL     = 4'd9,
    S_BRANCH  = 4'd10,
    S_JALR    = 4'd11,
    S_LUI     = 4'd12,
    S_AUIPC   = 4'd13,
    S_TRAP    = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam int unsigned WD_W =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Counter value during the last tolerated not-ready cycle.
  localparam logic [WD_W-1:0] WD_LAST =
    (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t          state;
  logic [WD_W-1:0] wd_cnt;
  logic            mem_go;
  logic            in_wait;
  logic            wd_expire;
  logic            branch_legal;
  logic [3:0]      alu_fn;
  logic            funct7_unused;

  // Only funct7[5] carries meaning for the supported instructions.
  assign funct7_unused = ^{funct7[6], funct7[4:0]};

  assign current_state = state;
  assign mem_go        = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign in_wait       = (state == S_FETCH) || (state == S_MEM_RD) ||
                         (state == S_MEM_WR);
  assign wd_expire     = (TIMEOUT_CYCLES != 0) && in_wait && !mem_go &&
                         (wd_cnt == WD_LAST);
  assign branch_legal  = (funct3[2:1] == 2'b00);

  // ALU operation from funct3/funct7[5]; sub only for R-type.
  always_comb begin
    alu_fn = ALU_ADD;
    case (funct3)
      3'b000:  alu_fn = ((state == S_EXEC_R) && funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_fn = ALU_SLL;
      3'b010:  alu_fn = ALU_SLT;
      3'b011:  alu_fn = ALU_SLTU;
      3'b100:  alu_fn = ALU_XOR;
      3'b101:  alu_fn = funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  alu_fn = ALU_OR;
      default: alu_fn = ALU_AND;
    endcase
  end

  // Immediate format follows the opcode in every state.
  always_comb begin
    imm_src = 3'b000;
    case (opcode)
      OP_LOAD, OP_I, OP_JALR: imm_src = 3'b000;
      OP_STORE:               imm_src = 3'b001;
      OP_BR:                  imm_src = 3'b010;
      OP_LUI, OP_AUIPC:       imm_src = 3'b011;
      OP_JAL:                 imm_src = 3'b100;
      default:                imm_src = 3'b000;
    endcase
  end

  // State sequencing, watchdog, sticky trap flags and retire pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_FETCH;
      wd_cnt        <= '0;
      illegal_instr <= 1'b0;
      mem_timeout   <= 1'b0;
      instr_retired <= 1'b0;
    end else begin
      instr_retired <= 1'b0;

      // Counts consecutive not-ready cycles within one wait state.
      if (in_wait && !mem_go && !wd_expire) wd_cnt <= wd_cnt + 1'b1;
      else                                  wd_cnt <= '0;

      case (state)
        S_FETCH: begin
          if (mem_go) state <= S_DECODE;
          else if (wd_expire) begin
            state       <= S_TRAP;
            mem_timeout <= 1'b1;
          end
        end
        S_DECODE: begin
          case (opcode)
            OP_LOAD, OP_STORE: state <= S_MEM_ADR;
            OP_R:              state <= S_EXEC_R;
            OP_I:              state <= S_EXEC_I;
            OP_BR:             state <= S_BRANCH;
            OP_JAL:            state <= S_JAL;
            OP_JALR:           state <= S_JALR;
            OP_LUI: begin
              if (SUPPORT_UPPER) state <= S_LUI;
              else begin
                state         <= S_TRAP;
                illegal_instr <= 1'b1;
              end
            end
            OP_AUIPC: begin
              if (SUPPORT_UPPER) state <= S_AUIPC;
              else begin
                state         <= S_TRAP;
                illegal_instr <= 1'b1;
              end
            end
            default: begin
              state         <= S_TRAP;
              illegal_instr <= 1'b1;
            end
          endcase
        end
        // opcode[5] separates store (0100011) from load (0000011).
        S_MEM_ADR: state <= opcode[5] ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD: begin
          if (mem_go) state <= S_MEM_WB;
          else if (wd_expire) begin
            state       <= S_TRAP;
            mem_timeout <= 1'b1;
          end
        end
        S_MEM_WB: begin
          state         <= S_FETCH;
          instr_retired <= 1'b1;
        end
        S_MEM_WR: begin
          if (mem_go) begin
            state         <= S_FETCH;
            instr_retired <= 1'b1;
          end else if (wd_expire) begin
            state       <= S_TRAP;
            mem_timeout <= 1'b1;
          end
        end
        S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC: state <= S_ALU_WB;
        S_ALU_WB: begin
          state         <= S_FETCH;
          instr_retired <= 1'b1;
        end
        S_BRANCH: begin
          if (branch_legal) begin
            state         <= S_FETCH;
            instr_retired <= 1'b1;
          end else begin
            state         <= S_TRAP;
            illegal_instr <= 1'b1;
          end
        end
        S_JALR:  state <= S_JAL;
        S_JAL:   state <= S_ALU_WB;
        S_TRAP:  state <= S_TRAP;
        default: state <= S_TRAP;
      endcase
    end
  end

  // Datapath controls per state; write enables are forced low under reset.
  always_comb begin
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    case (state)
      S_FETCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        ir_write   = mem_go;
        pc_write   = mem_go;
      end
      S_DECODE: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
      end
      S_MEM_ADR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: adr_src = 1'b1;
      S_MEM_WB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a   = 2'b01;
        alu_control = alu_fn;
      end
      S_EXEC_I: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b10;
        alu_control = alu_fn;
      end
      S_ALU_WB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a   = 2'b01;
        alu_control = ALU_SUB;
        pc_write    = branch_legal & (zero ^ funct3[0]);
      end
      S_JALR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
      end
      S_JAL: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        pc_write  = 1'b1;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b10;
      end
      S_AUIPC: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
      end
      default: ;
    endcase
    if (reset) begin
      mem_write = 1'b0;
      reg_write = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
    end
  end

endmodule
